// File: rtl/fir_pkg.sv
// fir_pkg: shared parameters, FSM states, default taps and history index helper
package fir_pkg;
  localparam int N = 15;
  localparam int XW = 12;
  localparam int CW = 16;
  localparam int YW = 32;
  localparam int PW = XW + CW;
  localparam int AW = 4;
  localparam int TW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  localparam logic signed [CW-1:0] H_DEF [N] = '{
    16'sd1, -16'sd2, 16'sd2, 16'sd18, -16'sd8, -16'sd62, 16'sd6, 16'sd90,
    16'sd6, -16'sd62, -16'sd8, 16'sd18, 16'sd2, -16'sd2, 16'sd1};
  // Slot holding the sample tap positions older than the newest; wp points one past the newest.
  function automatic logic [AW-1:0] hist_idx(input logic [AW-1:0] wp, input logic [TW-1:0] tap);
    logic [AW:0] s;
    s = {1'b0, wp} + (AW+1)'(N - 1) - {1'b0, tap};
    return AW'(s >= (AW+1)'(N) ? s - (AW+1)'(N) : s);
  endfunction
endpackage

// File: rtl/fir_mac_seq_if.sv
// fir_mac_seq_if: sample/result handshakes, coefficient write port and busy flag
// master drives in_valid/x/out_ready/coef_*; slave drives in_ready/out_valid/y/busy
interface fir_mac_seq_if;
  import fir_pkg::*;
  logic in_valid;
  logic in_ready;
  logic signed [XW-1:0] x;
  logic out_valid;
  logic out_ready;
  logic signed [YW-1:0] y;
  logic coef_we;
  logic [AW-1:0] coef_addr;
  logic signed [CW-1:0] coef_data;
  logic busy;
  modport master(output in_valid, x, out_ready, coef_we, coef_addr, coef_data,
                 input in_ready, out_valid, y, busy);
  modport slave(input in_valid, x, out_ready, coef_we, coef_addr, coef_data,
                output in_ready, out_valid, y, busy);
endinterface

// File: rtl/fir_mac.sv
// fir_mac: pipelined signed multiply-accumulate
// clr_i zeroes the pipeline, en_i issues x_i*h_i, acc_o is the sum including the product in flight
module fir_mac
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [XW-1:0] x_i,
  input  logic signed [CW-1:0] h_i,
  output logic signed [YW-1:0] acc_o
);
  logic signed [PW-1:0] prod_q, prod_d;
  logic signed [YW-1:0] acc_q, acc_d;
  always_comb begin
    prod_d = (clr_i || !en_i) ? '0 : PW'(x_i) * PW'(h_i);
    acc_d = clr_i ? '0 : acc_o;
  end
  // Wraps modulo 2^YW; the product is sign-extended before adding.
  assign acc_o = acc_q + YW'(prod_q);
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      prod_q <= '0;
      acc_q <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q <= acc_d;
    end
endmodule

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: N-tap FIR sharing one MAC across taps
// clk/nreset plain ports; bus carries sample in, result out and coefficient writes
module fir_mac_seq
  import fir_pkg::*;
(
  input logic clk,
  input logic nreset,
  fir_mac_seq_if.slave bus
);
  state_t state_q, state_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [AW-1:0] wp_q, wp_d;
  logic ov_q, ov_d;
  logic signed [YW-1:0] y_q, acc;
  logic signed [XW-1:0] hist_q [N];
  logic signed [CW-1:0] h_q [N];
  logic accept, cwr, last;
  assign accept = bus.in_valid && state_q == IDLE;
  assign cwr = bus.coef_we && state_q == IDLE && bus.coef_addr < AW'(N);
  // The extra MAC cycle at tap N drains the product register into the result.
  assign last = tap_q == TW'(N);
  assign bus.in_ready = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.out_valid = ov_q;
  assign bus.y = y_q;
  fir_mac u_mac (
    .clk   (clk),
    .nreset(nreset),
    .clr_i (accept),
    .en_i  (state_q == MAC && !last),
    .x_i   (hist_q[hist_idx(wp_q, tap_q)]),
    .h_i   (h_q[tap_q]),
    .acc_o (acc)
  );
  always_comb begin
    state_d = state_q;
    tap_d = tap_q;
    wp_d = wp_q;
    ov_d = ov_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = MAC;
        tap_d = '0;
        wp_d = wp_q == AW'(N - 1) ? '0 : wp_q + AW'(1);
      end
      MAC: begin
        tap_d = last ? '0 : tap_q + TW'(1);
        state_d = last ? OUT : MAC;
        ov_d = last;
      end
      OUT: if (bus.out_ready) begin
        ov_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state_q <= IDLE;
      tap_q <= '0;
      wp_q <= '0;
      ov_q <= 1'b0;
      y_q <= '0;
      for (int i = 0; i < N; i++) begin
        hist_q[i] <= '0;
        h_q[i] <= H_DEF[i];
      end
    end else begin
      state_q <= state_d;
      tap_q <= tap_d;
      wp_q <= wp_d;
      ov_q <= ov_d;
      y_q <= (state_q == MAC && last) ? acc : y_q;
      if (accept) hist_q[wp_q] <= bus.x;
      if (cwr) h_q[bus.coef_addr] <= bus.coef_data;
    end
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: directed checks of fir_mac_seq with hand-computed results
module tb_fir_mac_seq;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int checks = 0;
  int errors = 0;
  int H [15] = '{1, -2, 2, 18, -8, -62, 6, 90, 6, -62, -8, 18, 2, -2, 1};
  int STEP [15] = '{100, -100, 100, 1900, 1100, -5100, -4500, 4500, 5100, -1100, -1900, -100, 100, -100, 0};
  fir_mac_seq_if bus();
  fir_mac_seq dut(.clk(clk), .nreset(nreset), .bus(bus));
  always #5 clk = ~clk;

  task automatic apply_reset();
    nreset = 1'b0;
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.out_ready = 1'b1;
    bus.coef_we = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
  endtask

  // Offers one sample (with optional same-edge coefficient write) and waits for its result.
  task automatic send(input logic signed [11:0] xv, input logic we, input logic [3:0] ad,
                      input logic signed [15:0] cd, output logic signed [31:0] yv, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin @(negedge clk); w++; end
    bus.x = xv;
    bus.in_valid = 1'b1;
    bus.coef_we = we;
    bus.coef_addr = ad;
    bus.coef_data = cd;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.coef_we = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin @(negedge clk); lat++; end
    if (w >= 200) lat = -1;
    yv = bus.y;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.y !== 32'sd0) begin errors++; $display("FAIL reset_y got %0d want 0", bus.y); end
  endtask

  task automatic test_impulse();
    logic signed [31:0] yv;
    int lat;
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      send(i == 0 ? 12'sd1 : 12'sd0, 1'b0, 4'd0, 16'sd0, yv, lat);
      checks++;
      if (yv !== H[i] || lat != 16) begin errors++; $display("FAIL impulse[%0d] got y=%0d lat=%0d want y=%0d lat=16", i, yv, lat, H[i]); end
    end
  endtask

  task automatic test_step();
    logic signed [31:0] yv;
    int lat;
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      send(12'sd100, 1'b0, 4'd0, 16'sd0, yv, lat);
      checks++;
      if (yv !== STEP[i]) begin errors++; $display("FAIL step[%0d] got %0d want %0d", i, yv, STEP[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic signed [31:0] yv;
    int lat;
    apply_reset();
    bus.out_ready = 1'b0;
    send(12'sd1, 1'b0, 4'd0, 16'sd0, yv, lat);
    bus.in_valid = 1'b1;
    bus.x = 12'sd50;
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got %b want 1", c, bus.out_valid); end
      checks++; if (bus.y !== 32'sd1) begin errors++; $display("FAIL bp_y[%0d] got %0d want 1", c, bus.y); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", c, bus.in_ready); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d] got %b want 1", c, bus.busy); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy got %b want 0", bus.busy); end
    checks++; if (bus.y !== 32'sd1) begin errors++; $display("FAIL bp_release_y got %0d want 1", bus.y); end
    send(12'sd0, 1'b0, 4'd0, 16'sd0, yv, lat);
    checks++; if (yv !== -32'sd2) begin errors++; $display("FAIL bp_ignored_sample got %0d want -2", yv); end
  endtask

  task automatic test_coef();
    logic signed [31:0] yv;
    int lat;
    apply_reset();
    send(12'sd3, 1'b1, 4'd0, 16'sd5, yv, lat);
    checks++; if (yv !== 32'sd15) begin errors++; $display("FAIL coef_same_edge got %0d want 15", yv); end
    @(negedge clk);
    bus.x = 12'sd1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.coef_we = 1'b1;
    bus.coef_addr = 4'd0;
    bus.coef_data = 16'sd7;
    @(negedge clk);
    bus.coef_we = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin @(negedge clk); lat++; end
    checks++; if (bus.y !== -32'sd1 || lat >= 200) begin errors++; $display("FAIL coef_busy_write got y=%0d wait=%0d want y=-1", bus.y, lat); end
  endtask

  task automatic test_extremes();
    logic signed [31:0] yv;
    int lat;
    apply_reset();
    send(-12'sd2048, 1'b1, 4'd15, 16'sd1234, yv, lat);
    checks++; if (yv !== -32'sd2048) begin errors++; $display("FAIL ext_min_y got %0d want -2048", yv); end
    checks++; if (lat != 16) begin errors++; $display("FAIL ext_latency got %0d want 16", lat); end
    send(12'sd0, 1'b1, 4'd0, 16'sh8000, yv, lat);
    checks++; if (yv !== 32'sd4096) begin errors++; $display("FAIL ext_second got %0d want 4096", yv); end
    send(-12'sd2048, 1'b0, 4'd0, 16'sd0, yv, lat);
    checks++; if (yv !== 32'sd67104768) begin errors++; $display("FAIL ext_full_product got %0d want 67104768", yv); end
  endtask

  task automatic test_reset_mid();
    logic signed [31:0] yv;
    int lat, seen;
    apply_reset();
    send(12'sd5, 1'b0, 4'd0, 16'sd0, yv, lat);
    @(negedge clk);
    bus.x = 12'sd5;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", bus.busy); end
    nreset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.y !== 32'sd0) begin
      errors++; $display("FAIL mid_async_reset got busy=%b ov=%b y=%0d want 0 0 0", bus.busy, bus.out_valid, bus.y); end
    @(negedge clk);
    nreset = 1'b1;
    seen = 0;
    for (int c = 0; c < 25; c++) begin @(negedge clk); if (bus.out_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_result got %0d valid cycles want 0", seen); end
    send(12'sd1, 1'b0, 4'd0, 16'sd0, yv, lat);
    checks++; if (yv !== 32'sd1) begin errors++; $display("FAIL mid_history_cleared got %0d want 1", yv); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_step();
    test_backpressure();
    test_coef();
    test_extremes();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
